// File: rtl/chip_6502.sv
// chip_6502 -- cycle-counted subset of the NMOS 6502 core, clocked by the
// FPGA system clock with the 6502 phase clock sampled as a cycle strobe.
// Optional feature: define CHIP_6502_SO_EN to honour the active-low
// set-overflow input (falling edge at a strobe sets V).
module chip_6502 #(
    parameter logic [15:0] RES_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        phi,
    input  logic        so,
    input  logic        rdy,
    input  logic        nmi,
    input  logic        irq,
    input  logic [7:0]  dbi,
    output logic [7:0]  dbo,
    output logic        rw,
    output logic        sync,
    output logic [15:0] ab
);

    typedef enum logic [2:0] {
        S_VEC0,   // reading reset vector low byte
        S_VEC1,   // reading reset vector high byte
        S_FETCH,  // opcode fetch
        S_OP1,    // second cycle: operand or dummy read
        S_OP2,    // absolute high byte
        S_OP3,    // absolute data read/write
        S_BR      // taken-branch extra cycle
    } state_t;

    state_t      state;
    logic        phi_q;
    logic        strobe;
    logic        stall;
    logic [7:0]  a_reg;
    logic [7:0]  x_reg;
    logic [7:0]  opcode;
    logic [7:0]  lo;
    logic [15:0] pc;
    logic        flag_n, flag_v, flag_z, flag_c;
    logic [15:0] pc_inc;
    logic [15:0] br_target;
    logic [8:0]  adc_sum;
    logic [7:0]  x_inc;
    logic [7:0]  x_dec;

    assign strobe    = phi & ~phi_q;
    // Only read cycles can be held off; a write cycle always completes.
    assign stall     = ~rdy & rw;
    assign pc_inc    = pc + 16'd1;
    assign br_target = pc_inc + {{8{dbi[7]}}, dbi};
    assign adc_sum   = {1'b0, a_reg} + {1'b0, dbi} + {8'd0, flag_c};
    assign x_inc     = x_reg + 8'd1;
    assign x_dec     = x_reg - 8'd1;

`ifdef CHIP_6502_SO_EN
    logic so_q;
    logic unused_inputs;
    assign unused_inputs = ^{nmi, irq};
`else
    logic unused_inputs;
    assign unused_inputs = ^{nmi, irq, so};
`endif

    // Phase-clock edge detector: phi is registered once per clk.
    always_ff @(posedge clk or negedge res) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!res) phi_q <= 1'b0;
        else      phi_q <= phi;
    end

    // Bus-cycle sequencer: registered bus outputs and architectural state.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state  <= S_VEC0;
            ab     <= RES_VECTOR;
            rw     <= 1'b1;
            sync   <= 1'b0;
            dbo    <= 8'h00;
            a_reg  <= 8'h00;
            x_reg  <= 8'h00;
            pc     <= 16'h0000;
            opcode <= 8'h00;
            lo     <= 8'h00;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
`ifdef CHIP_6502_SO_EN
            so_q   <= 1'b1;
`endif
        end else begin
            if (strobe && !stall) begin
                // Default next cycle is a plain read; arms override as needed.
                rw   <= 1'b1;
                sync <= 1'b0;
                unique case (state)
                    S_VEC0: begin
                        lo    <= dbi;
                        ab    <= RES_VECTOR + 16'd1;
                        state <= S_VEC1;
                    end
                    S_VEC1: begin
                        pc    <= {dbi, lo};
                        ab    <= {dbi, lo};
                        sync  <= 1'b1;
                        state <= S_FETCH;
                    end
                    S_FETCH: begin
                        opcode <= dbi;
                        pc     <= pc_inc;
                        ab     <= pc_inc;
                        state  <= S_OP1;
                    end
                    S_OP1: begin
                        // Implied and unknown opcodes: dummy read done, PC kept.
                        ab    <= pc;
                        sync  <= 1'b1;
                        state <= S_FETCH;
                        case (opcode)
                            8'hA9, 8'hA2, 8'h69: begin
                                pc   <= pc_inc;
                                ab   <= pc_inc;
                                if (opcode == 8'hA9) begin
                                    a_reg  <= dbi;
                                    flag_n <= dbi[7];
                                    flag_z <= (dbi == 8'h00);
                                end else if (opcode == 8'hA2) begin
                                    x_reg  <= dbi;
                                    flag_n <= dbi[7];
                                    flag_z <= (dbi == 8'h00);
                                end else begin
                                    a_reg  <= adc_sum[7:0];
                                    flag_c <= adc_sum[8];
                                    flag_v <= (a_reg[7] == dbi[7]) && (adc_sum[7] != a_reg[7]);
                                    flag_n <= adc_sum[7];
                                    flag_z <= (adc_sum[7:0] == 8'h00);
                                end
                            end
                            8'hAD, 8'h8D, 8'h4C: begin
                                lo    <= dbi;
                                pc    <= pc_inc;
                                ab    <= pc_inc;
                                sync  <= 1'b0;
                                state <= S_OP2;
                            end
                            8'hD0: begin
                                if (!flag_z) begin
                                    // Extra cycle re-reads the next opcode address.
                                    pc    <= br_target;
                                    ab    <= pc_inc;
                                    sync  <= 1'b0;
                                    state <= S_BR;
                                end else begin
                                    pc <= pc_inc;
                                    ab <= pc_inc;
                                end
                            end
                            8'hE8: begin
                                x_reg  <= x_inc;
                                flag_n <= x_inc[7];
                                flag_z <= (x_inc == 8'h00);
                            end
                            8'hCA: begin
                                x_reg  <= x_dec;
                                flag_n <= x_dec[7];
                                flag_z <= (x_dec == 8'h00);
                            end
                            8'h18:   flag_c <= 1'b0;
                            8'h38:   flag_c <= 1'b1;
                            default: ;
                        endcase
                    end
                    S_OP2: begin
                        pc <= pc_inc;
                        if (opcode == 8'h4C) begin
                            pc    <= {dbi, lo};
                            ab    <= {dbi, lo};
                            sync  <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            ab    <= {dbi, lo};
                            state <= S_OP3;
                            if (opcode == 8'h8D) begin
                                rw  <= 1'b0;
                                dbo <= a_reg;
                            end
                        end
                    end
                    S_OP3: begin
                        if (opcode == 8'hAD) begin
                            a_reg  <= dbi;
                            flag_n <= dbi[7];
                            flag_z <= (dbi == 8'h00);
                        end
                        ab    <= pc;
                        sync  <= 1'b1;
                        state <= S_FETCH;
                    end
                    S_BR: begin
                        ab    <= pc;
                        sync  <= 1'b1;
                        state <= S_FETCH;
                    end
                    default: begin
                        ab    <= RES_VECTOR;
                        state <= S_VEC0;
                    end
                endcase
            end
`ifdef CHIP_6502_SO_EN
            // Set-overflow edge wins over any V update from the instruction.
            if (strobe) begin
                so_q <= so;
                if (so_q && !so) flag_v <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_chip_6502.sv
// tb_chip_6502 -- self-checking bench for chip_6502: a 64 KiB memory model
// answers bus reads, and expected bus cycles are queued per program and
// popped as the core presents each cycle.
module tb_chip_6502;

    logic        clk;
    logic        res;
    logic        phi;
    logic        so;
    logic        rdy;
    logic        nmi;
    logic        irq;
    logic [7:0]  dbi;
    logic [7:0]  dbo;
    logic        rw;
    logic        sync;
    logic [15:0] ab;

    typedef struct packed {
        logic [15:0] ab;
        logic        rw;
        logic        sync;
        logic [7:0]  dbo;
    } bus_t;

    bus_t       exp_q [$];
    logic [7:0] mem [0:65535];
    int         checks = 0;
    int         errors = 0;

    chip_6502 dut (
        .clk  (clk),
        .res  (res),
        .phi  (phi),
        .so   (so),
        .rdy  (rdy),
        .nmi  (nmi),
        .irq  (irq),
        .dbi  (dbi),
        .dbo  (dbo),
        .rw   (rw),
        .sync (sync),
        .ab   (ab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb dbi = mem[ab];

    // One bus cycle: commit a pending write, raise phi for one clk, then
    // return on a falling clk edge with the next cycle's outputs settled.
    task automatic tick();
        if (rw === 1'b0) mem[ab] = dbo;
        @(negedge clk);
        phi = 1'b1;
        @(negedge clk);
        phi = 1'b0;
        @(negedge clk);
    endtask

    task automatic exp_bus(input logic [15:0] a, input logic r, input logic s, input logic [7:0] d);
        exp_q.push_back({a, r, s, d});
    endtask

    // Hold reset, wipe memory and install the vector 8000.
    task automatic hold_reset();
        res = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        tick();
        tick();
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if (ab !== 16'hFFFC || rw !== 1'b1 || sync !== 1'b0 || dbo !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got ab=%h rw=%b sync=%b dbo=%h, want ab=fffc rw=1 sync=0 dbo=00", ab, rw, sync, dbo);
        end
        checks++;
        if (dut.a_reg !== 8'h00 || dut.x_reg !== 8'h00 || dut.pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: got a=%h x=%h pc=%h, want 00 00 0000", dut.a_reg, dut.x_reg, dut.pc);
        end
        checks++;
        if ({dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got nvzc=%b, want 0000",
                     {dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c});
        end
    endtask

    // Vector fetch, immediate load and absolute store, then a JMP self-loop.
    task automatic test_store();
        bus_t e;
        logic [7:0] prog [0:7] = '{8'hA9, 8'h55, 8'h8D, 8'h00, 8'h02, 8'h4C, 8'h05, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        exp_bus(16'hFFFC, 1, 0, 8'h00); exp_bus(16'hFFFD, 1, 0, 8'h00);
        exp_bus(16'h8000, 1, 1, 8'h00); exp_bus(16'h8001, 1, 0, 8'h00);
        exp_bus(16'h8002, 1, 1, 8'h00); exp_bus(16'h8003, 1, 0, 8'h00);
        exp_bus(16'h8004, 1, 0, 8'h00); exp_bus(16'h0200, 0, 0, 8'h55);
        exp_bus(16'h8005, 1, 1, 8'h55); exp_bus(16'h8006, 1, 0, 8'h55);
        exp_bus(16'h8007, 1, 0, 8'h55); exp_bus(16'h8005, 1, 1, 8'h55);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if (ab !== e.ab || rw !== e.rw || sync !== e.sync || dbo !== e.dbo) begin
                errors++;
                $display("FAIL store cycle %0d: got ab=%h rw=%b sync=%b dbo=%h, want ab=%h rw=%b sync=%b dbo=%h",
                         n, ab, rw, sync, dbo, e.ab, e.rw, e.sync, e.dbo);
            end
            tick();
        end
        checks++;
        if (mem[16'h0200] !== 8'h55) begin
            errors++;
            $display("FAIL store_mem: got %h, want 55", mem[16'h0200]);
        end
    endtask

    // LDX #3; DEX; BNE back; JMP 8000.
    task automatic test_loop();
        bus_t e;
        logic [7:0] prog [0:7] = '{8'hA2, 8'h03, 8'hCA, 8'hD0, 8'hFD, 8'h4C, 8'h00, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        exp_bus(16'hFFFC, 1, 0, 8'h00); exp_bus(16'hFFFD, 1, 0, 8'h00);
        exp_bus(16'h8000, 1, 1, 8'h00); exp_bus(16'h8001, 1, 0, 8'h00);
        for (int x_after = 2; x_after >= 0; x_after--) begin
            exp_bus(16'h8002, 1, 1, 8'h00); exp_bus(16'h8003, 1, 0, 8'h00);
            exp_bus(16'h8003, 1, 1, 8'h00); exp_bus(16'h8004, 1, 0, 8'h00);
            if (x_after != 0) exp_bus(16'h8005, 1, 0, 8'h00);
        end
        exp_bus(16'h8005, 1, 1, 8'h00); exp_bus(16'h8006, 1, 0, 8'h00);
        exp_bus(16'h8007, 1, 0, 8'h00); exp_bus(16'h8000, 1, 1, 8'h00);
        exp_bus(16'h8001, 1, 0, 8'h00);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if (ab !== e.ab || rw !== e.rw || sync !== e.sync || dbo !== e.dbo) begin
                errors++;
                $display("FAIL loop cycle %0d: got ab=%h rw=%b sync=%b dbo=%h, want ab=%h rw=%b sync=%b dbo=%h",
                         n, ab, rw, sync, dbo, e.ab, e.rw, e.sync, e.dbo);
            end
            tick();
        end
        checks++;
        if (dut.x_reg !== 8'h03 || dut.flag_z !== 1'b0 || dut.flag_n !== 1'b0) begin
            errors++;
            $display("FAIL loop_reload: got x=%h z=%b n=%b, want x=03 z=0 n=0", dut.x_reg, dut.flag_z, dut.flag_n);
        end
    endtask

    // SEC; LDA #7F; ADC #00; STA 0300; JMP self.
    task automatic test_arith();
        bus_t e;
        logic [7:0] prog [0:10] = '{8'h38, 8'hA9, 8'h7F, 8'h69, 8'h00, 8'h8D, 8'h00, 8'h03,
                                    8'h4C, 8'h08, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        exp_bus(16'hFFFC, 1, 0, 8'h00); exp_bus(16'hFFFD, 1, 0, 8'h00);
        exp_bus(16'h8000, 1, 1, 8'h00); exp_bus(16'h8001, 1, 0, 8'h00);
        exp_bus(16'h8001, 1, 1, 8'h00); exp_bus(16'h8002, 1, 0, 8'h00);
        exp_bus(16'h8003, 1, 1, 8'h00); exp_bus(16'h8004, 1, 0, 8'h00);
        exp_bus(16'h8005, 1, 1, 8'h00); exp_bus(16'h8006, 1, 0, 8'h00);
        exp_bus(16'h8007, 1, 0, 8'h00); exp_bus(16'h0300, 0, 0, 8'h80);
        exp_bus(16'h8008, 1, 1, 8'h80);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if (ab !== e.ab || rw !== e.rw || sync !== e.sync || dbo !== e.dbo) begin
                errors++;
                $display("FAIL arith cycle %0d: got ab=%h rw=%b sync=%b dbo=%h, want ab=%h rw=%b sync=%b dbo=%h",
                         n, ab, rw, sync, dbo, e.ab, e.rw, e.sync, e.dbo);
            end
            tick();
        end
        checks++;
        if (dut.a_reg !== 8'h80 || {dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c} !== 4'b1100) begin
            errors++;
            $display("FAIL arith_result: got a=%h nvzc=%b, want a=80 nvzc=1100",
                     dut.a_reg, {dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c});
        end
    endtask

    // LDX #FF; INX; DEX -- wrap in both directions.
    task automatic test_inx_wrap();
        logic [7:0] prog [0:6] = '{8'hA2, 8'hFF, 8'hE8, 8'hCA, 8'h4C, 8'h04, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        repeat (6) tick();
        checks++;
        if (dut.x_reg !== 8'h00 || dut.flag_z !== 1'b1 || dut.flag_n !== 1'b0) begin
            errors++;
            $display("FAIL inx_wrap: got x=%h z=%b n=%b, want x=00 z=1 n=0", dut.x_reg, dut.flag_z, dut.flag_n);
        end
        repeat (2) tick();
        checks++;
        if (dut.x_reg !== 8'hFF || dut.flag_z !== 1'b0 || dut.flag_n !== 1'b1) begin
            errors++;
            $display("FAIL dex_wrap: got x=%h z=%b n=%b, want x=ff z=0 n=1", dut.x_reg, dut.flag_z, dut.flag_n);
        end
    endtask

    // NOP; STA 1234; JMP 8000 -- stall an opcode fetch, then try to stall the write.
    task automatic test_rdy_stall();
        bus_t e;
        logic [7:0] prog [0:6] = '{8'hEA, 8'h8D, 8'h34, 8'h12, 8'h4C, 8'h00, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        exp_bus(16'hFFFC, 1, 0, 8'h00); exp_bus(16'hFFFD, 1, 0, 8'h00);
        exp_bus(16'h8000, 1, 1, 8'h00); exp_bus(16'h8001, 1, 0, 8'h00);
        exp_bus(16'h8001, 1, 1, 8'h00); exp_bus(16'h8002, 1, 0, 8'h00);
        exp_bus(16'h8003, 1, 0, 8'h00); exp_bus(16'h1234, 0, 0, 8'h00);
        exp_bus(16'h8004, 1, 1, 8'h00); exp_bus(16'h8005, 1, 0, 8'h00);
        exp_bus(16'h8006, 1, 0, 8'h00); exp_bus(16'h8000, 1, 1, 8'h00);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if (ab !== e.ab || rw !== e.rw || sync !== e.sync || dbo !== e.dbo) begin
                errors++;
                $display("FAIL rdy cycle %0d: got ab=%h rw=%b sync=%b dbo=%h, want ab=%h rw=%b sync=%b dbo=%h",
                         n, ab, rw, sync, dbo, e.ab, e.rw, e.sync, e.dbo);
            end
            if (n == 4) begin
                rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++;
                    if (ab !== 16'h8001 || sync !== 1'b1 || rw !== 1'b1 || dut.pc !== 16'h8001) begin
                        errors++;
                        $display("FAIL rdy_hold %0d: got ab=%h sync=%b rw=%b pc=%h, want ab=8001 sync=1 rw=1 pc=8001",
                                 s, ab, sync, rw, dut.pc);
                    end
                end
                rdy = 1'b1;
            end
            rdy = (n == 7) ? 1'b0 : 1'b1;
            tick();
            rdy = 1'b1;
        end
    endtask

    // Reset pulsed during the STA write cycle must abort it and refetch the vector.
    task automatic test_mid_reset();
        bus_t e;
        logic [7:0] prog [0:7] = '{8'hA9, 8'h55, 8'h8D, 8'h00, 8'h02, 8'h4C, 8'h05, 8'h80};
        hold_reset();
        foreach (prog[i]) mem[16'h8000 + 16'(i)] = prog[i];
        res = 1'b1;
        repeat (7) tick();
        checks++;
        if (ab !== 16'h0200 || rw !== 1'b0 || dbo !== 8'h55) begin
            errors++;
            $display("FAIL midrst_pre: got ab=%h rw=%b dbo=%h, want ab=0200 rw=0 dbo=55", ab, rw, dbo);
        end
        #2 res = 1'b0;
        #1;
        checks++;
        if (rw !== 1'b1 || ab !== 16'hFFFC || sync !== 1'b0 || dbo !== 8'h00) begin
            errors++;
            $display("FAIL midrst_abort: got ab=%h rw=%b sync=%b dbo=%h, want ab=fffc rw=1 sync=0 dbo=00",
                     ab, rw, sync, dbo);
        end
        @(negedge clk);
        tick();
        res = 1'b1;
        exp_bus(16'hFFFC, 1, 0, 8'h00); exp_bus(16'hFFFD, 1, 0, 8'h00);
        exp_bus(16'h8000, 1, 1, 8'h00); exp_bus(16'h8001, 1, 0, 8'h00);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if (ab !== e.ab || rw !== e.rw || sync !== e.sync || dbo !== e.dbo) begin
                errors++;
                $display("FAIL midrst cycle %0d: got ab=%h rw=%b sync=%b dbo=%h, want ab=%h rw=%b sync=%b dbo=%h",
                         n, ab, rw, sync, dbo, e.ab, e.rw, e.sync, e.dbo);
            end
            tick();
        end
        checks++;
        if (mem[16'h0200] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_nowrite: got %h, want 00", mem[16'h0200]);
        end
    endtask

    initial begin
        res = 1'b0;
        phi = 1'b0;
        so  = 1'b1;
        rdy = 1'b1;
        nmi = 1'b1;
        irq = 1'b1;
        test_reset();
        test_store();
        test_loop();
        test_arith();
        test_inx_wrap();
        test_rdy_stall();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
